// File: rtl/uart_rx.sv
// 8N1-style UART receiver: two-flop synchronizer, start-bit qualification at
// half a bit period, midpoint sampling of LSB-first data, and stop-bit check.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    // Output handshake: rx_valid is a single-cycle strobe with no ready/backpressure;
    // rx_data is stable from the rx_valid edge until the next good frame.

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] IDX_ONE  = BW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]           state;
    logic                 ff1;
    logic                 rx_s;
    logic                 rx_s_d;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitidx;
    logic [DATA_BITS-1:0] shreg;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer clears low so a line already low at reset never looks like a start edge.
            ff1       <= 1'b0;
            rx_s      <= 1'b0;
            rx_s_d    <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ff1       <= rx;
            rx_s      <= ff1;
            rx_s_d    <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s && rx_s_d) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        // Still low at mid start bit: a real start, otherwise a glitch.
                        if (!rx_s) begin
                            state  <= DATA;
                            cnt    <= '0;
                            bitidx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == BIT_M1) begin
                        shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt    <= '0;
                        bitidx <= bitidx + IDX_ONE;
                        if (bitidx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt == BIT_M1) begin
                        // Returning to IDLE at the stop midpoint lets a back-to-back start edge be seen.
                        state <= IDLE;
                        cnt   <= '0;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed-plus-random bench for uart_rx: default build and a CLKS_PER_BIT=4,
// DATA_BITS=7 build, both checked against a frame-level reference model.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int CPB2 = 4;
    localparam int DB2  = 7;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] t;
        logic [7:0]  data;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           rx;
    logic           rx2;
    logic [DB-1:0]  rx_data;
    logic           rx_valid;
    logic           frame_err;
    logic           busy;
    logic [1:0]     state_dbg;
    logic [DB2-1:0] rx_data2;
    logic           rx_valid2;
    logic           frame_err2;
    logic           busy2;
    logic [1:0]     state_dbg2;

    logic [63:0] cyc = 64'd0;
    int          busy_cnt0 = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    ev_t         obs0[$];
    ev_t         obs1[$];
    logic [7:0]  exp_q[$];
    logic [63:0] exp_t_q[$];
    logic [1:0]  exp_k_q[$];
    logic [7:0]  last_good[2];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .busy(busy), .state_dbg(state_dbg)
    );

    uart_rx #(.CLKS_PER_BIT(CPB2), .DATA_BITS(DB2)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .frame_err(frame_err2),
        .busy(busy2), .state_dbg(state_dbg2)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;

    // monitor: record every output pulse with the index of the edge that produced it
    always @(negedge clk) begin
        ev_t m;
        if (rx_valid || frame_err) begin
            m.kind = {frame_err, rx_valid};
            m.t    = cyc;
            m.data = rx_data;
            obs0.push_back(m);
        end
        if (rx_valid2 || frame_err2) begin
            m.kind = {frame_err2, rx_valid2};
            m.t    = cyc;
            m.data = {1'b0, rx_data2};
            obs1.push_back(m);
        end
        if (busy) busy_cnt0++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx = v;
        else          rx2 = v;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
    endtask

    // driver: called at a negedge; the next posedge is E0
    task automatic send_frame(input int sel, input logic [7:0] d, input int nb, input int cpb,
                              input logic stop_v, output logic [63:0] e0);
        e0 = cyc + 64'd1;
        set_line(sel, 1'b0);
        idle(cpb);
        for (int i = 0; i < nb; i++) begin
            set_line(sel, d[i]);
            idle(cpb);
        end
        set_line(sel, stop_v);
        idle(cpb);
    endtask

    // reference model: decode the transmitted line levels and predict the outcome
    task automatic expect_frame(input int sel, input logic [7:0] d, input int nb, input int cpb,
                                input logic stop_v, input logic [63:0] e0);
        logic line[$];
        int   val;
        line.push_back(1'b0);
        for (int i = 0; i < nb; i++) line.push_back(d[i]);
        line.push_back(stop_v);
        val = 0;
        for (int i = 0; i < nb; i++) val += int'(line[i+1]) * (1 << i);
        if (line[nb+1]) begin
            exp_k_q.push_back(2'b01);
            exp_q.push_back(8'(val));
            last_good[sel] = 8'(val);
        end else begin
            exp_k_q.push_back(2'b10);
            exp_q.push_back(last_good[sel]);
        end
        exp_t_q.push_back(e0 + 64'(2 + cpb / 2 + (nb + 1) * cpb));
    endtask

    task automatic frame(input int sel, input logic [7:0] d, input logic stop_v);
        logic [63:0] e0;
        int nb  = (sel == 0) ? DB : DB2;
        int cpb = (sel == 0) ? CPB : CPB2;
        send_frame(sel, d, nb, cpb, stop_v, e0);
        expect_frame(sel, d, nb, cpb, stop_v, e0);
    endtask

    // scoreboard: pair each expected event with the next observed one
    task automatic check_events(input int sel, input string tag);
        ev_t         e;
        logic [7:0]  xd;
        logic [63:0] xt;
        logic [1:0]  xk;
        int          left;
        while (exp_q.size() > 0) begin
            xd = exp_q.pop_front();
            xt = exp_t_q.pop_front();
            xk = exp_k_q.pop_front();
            e  = '{2'd0, 64'd0, 8'd0};
            if (sel == 0 && obs0.size() > 0)      e = obs0.pop_front();
            else if (sel == 1 && obs1.size() > 0) e = obs1.pop_front();
            check({tag, "_kind"}, 64'(e.kind), 64'(xk));
            check({tag, "_time"}, e.t, xt);
            check({tag, "_data"}, 64'(e.data), 64'(xd));
        end
        left = (sel == 0) ? obs0.size() : obs1.size();
        check({tag, "_extra_events"}, 64'(left), 64'd0);
        obs0.delete();
        obs1.delete();
    endtask

    initial begin
        int          b0;
        int          g;
        logic [63:0] e0;
        logic [7:0]  d;

        rst = 1'b1;
        rx  = 1'b1;
        rx2 = 1'b1;
        @(negedge clk);
        do_reset(3);

        // reset values
        check("rst_rx_data",   64'(rx_data), 64'd0);
        check("rst_rx_valid",  64'(rx_valid), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_state",     64'(state_dbg), 64'd0);
        check("rst_rx_data2",  64'(rx_data2), 64'd0);

        // single byte
        idle(20);
        frame(0, 8'h55, 1'b1);
        idle(10);
        check_events(0, "single");
        check("single_hold", 64'(rx_data), 64'h55);

        // back-to-back: second start begins right after the first stop bit
        frame(0, 8'hA5, 1'b1);
        frame(0, 8'h3C, 1'b1);
        idle(10);
        check("b2b_spacing", exp_t_q[1] - exp_t_q[0], 64'd160);
        check_events(0, "b2b");

        // random bytes with random gaps, including zero gap
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom_range(0, 255));
            idle($urandom_range(0, 20));
            frame(0, d, 1'b1);
        end
        idle(10);
        check_events(0, "rand");

        // start glitches: fixed 4-cycle low pulse, then random short ones
        for (int k = 0; k < 4; k++) begin
            g  = (k == 0) ? 4 : $urandom_range(1, CPB / 2 - 2);
            idle(20);
            b0 = busy_cnt0;
            rx = 1'b0;
            idle(g);
            rx = 1'b1;
            idle(30);
            check("glitch_busy_len", 64'(busy_cnt0 - b0), 64'(CPB / 2));
            check_events(0, "glitch");
        end
        frame(0, 8'h81, 1'b1);
        idle(10);
        check_events(0, "post_glitch");

        // frame error followed by a 400-cycle break
        do_reset(2);
        idle(20);
        frame(0, 8'hF0, 1'b0);
        b0 = busy_cnt0;
        idle(400);
        check("break_busy", 64'(busy_cnt0 - b0), 64'd0);
        rx = 1'b1;
        idle(20);
        check_events(0, "ferr");
        check("ferr_hold", 64'(rx_data), 64'h00);
        frame(0, 8'h12, 1'b1);
        idle(10);
        check_events(0, "post_break");

        // reset in the middle of data bit 3 of an 0xFF frame
        idle(20);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(3 * CPB + CPB / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        check("midrst_rx_data",   64'(rx_data), 64'd0);
        check("midrst_rx_valid",  64'(rx_valid), 64'd0);
        check("midrst_frame_err", 64'(frame_err), 64'd0);
        check("midrst_busy",      64'(busy), 64'd0);
        idle(200);
        check_events(0, "midrst_quiet");
        frame(0, 8'h7E, 1'b1);
        idle(10);
        check_events(0, "post_midrst");

        // alternate build: CLKS_PER_BIT=4, DATA_BITS=7
        idle(10);
        send_frame(1, 8'h5A, DB2, CPB2, 1'b1, e0);
        expect_frame(1, 8'h5A, DB2, CPB2, 1'b1, e0);
        check("alt_latency", exp_t_q[0] - e0, 64'd36);
        idle(10);
        check_events(1, "alt_5a");
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 127));
            idle($urandom_range(0, 6));
            frame(1, d, (k == 3) ? 1'b0 : 1'b1);
            if (k == 3) begin
                rx2 = 1'b1;
                idle(6);
            end
        end
        idle(10);
        check_events(1, "alt_rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: the receiving end of the 8N1, LSB-first, idle-high framing used by the transmit path. It synchronizes the asynchronous `rx` line, detects the start bit, and samples each bit at its midpoint using a bit-period counter. It assembles the data bits in a right-shifting register and presents each completed byte with a one-cycle valid pulse. The block sits between the board pin and the byte-level consumer; there is no flow control, so the consumer must accept `rx_data` while `rx_valid` is high.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; must be even and at least 4. `HALF` = `CLKS_PER_BIT`/2.
- `DATA_BITS`, 8: data bits per frame, range 5–8.

- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous reset, active-high.
- `rx`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  `DATA_BITS`  last correctly framed byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low, byte discarded.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Synchronizer:** two flops, `rx` → `ff1` → `rx_s`, plus a delay flop `rx_s_d`. All three reset to 0, so a line held low at or after reset is never taken as a start bit.
- **Start detect:** a falling edge is `rx_s`=0 with `rx_s_d`=1, evaluated only in IDLE.
- **State machine:**
  - IDLE: on a falling edge, go to START with `cnt`=0.
  - START: `cnt` increments each cycle. When `cnt`=`HALF`-1, sample `rx_s`:
    - `rx_s`=0: go to DATA with `cnt`=0 and `bitidx`=0.
    - `rx_s`=1: glitch; return to IDLE with no output.
  - DATA: when `cnt`=`CLKS_PER_BIT`-1, shift in with `shreg` <= {`rx_s`, `shreg`[`DATA_BITS`-1:1]} (first received bit ends in bit 0), clear `cnt`, and increment `bitidx`. After the `DATA_BITS`-th sample, go to STOP.
  - STOP: when `cnt`=`CLKS_PER_BIT`-1, sample `rx_s` and go to IDLE.
    - `rx_s`=1: load `rx_data` <= `shreg` and pulse `rx_valid`.
    - `rx_s`=0: pulse `frame_err`; `rx_data` is unchanged.
- **Counter widths:** `cnt` is wide enough for `CLKS_PER_BIT`-1; `bitidx` is wide enough for `DATA_BITS`. No wrap occurs inside a state.
- **Break (line held low):** produces one `frame_err`, then stays in IDLE until the line goes high and falls again.
- **Back-to-back frames:** IDLE is re-entered at the stop-bit midpoint, so a start edge beginning at the next bit boundary is accepted with no gap.
- **Reset mid-frame:** the state returns to IDLE. `rx_data`, `rx_valid`, `frame_err`, `busy`, `shreg`, `cnt` and `bitidx` all clear to 0. The remainder of the interrupted frame is ignored until a 1→0 transition occurs.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.
- **Reference edge E0:** the clock edge that first samples `rx` low.
- **State entries:**
  - START is entered at E0+2, and `busy` is high from then on.
  - Data bit i (i = 0 … `DATA_BITS`-1) is sampled at E0+2+`HALF`+(i+1)·`CLKS_PER_BIT`.
- **Stop sample:** taken at edge S = E0+2+`HALF`+(`DATA_BITS`+1)·`CLKS_PER_BIT`. At defaults this is E0+154.
- **At edge S:**
  - `rx_valid` or `frame_err` is high for exactly the one cycle after S.
  - `rx_data` updates at the same edge as `rx_valid` rises.
  - `busy` falls at the same edge.
- `rx_valid` and `frame_err` are never high in the same cycle.
- **Glitch rejection:** a low pulse shorter than `HALF`-1 cycles, as seen on `rx_s`, produces no output. `busy` is high for exactly `HALF` cycles.

## Test plan
- **Single byte:** reset, then hold `rx`=1 for 20 cycles and send 0x55 at 16 clk/bit. Required: `rx_valid` for one cycle at E0+154, `rx_data`=0x55, `frame_err`=0 throughout.
- **Back-to-back frames:** send 0xA5 immediately followed by 0x3C. Required: two `rx_valid` pulses exactly 160 cycles apart, with `rx_data`=0xA5 and then 0x3C.
- **Start glitch:** drive `rx` low for 4 cycles, then high. Required: `busy` high for 8 cycles, no `rx_valid`, no `frame_err`. A following frame with 0x81 is received correctly.
- **Frame error and break:** send 0xF0 with the stop bit low, keep `rx` low for 400 cycles, then send 0x12. Required: exactly one `frame_err` and `rx_data` still 0x00. `busy` stays low during the break. 0x12 is then received with `rx_valid`.
- **Reset mid-frame:** start 0xFF, assert `rst` for 1 cycle during bit 3, and leave the line high afterwards. Required: all outputs 0 after reset and no pulse for the aborted frame. The next frame 0x7E gives `rx_data`=0x7E.
- **Alternate parameters:** build with `CLKS_PER_BIT`=4 and `DATA_BITS`=7, then send 0x5A. Required: `rx_valid` at E0+2+2+8·4 = E0+36, `rx_data`=0x5A.
